// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial shifter with one holding register, so words stream with no gaps.
// Feeds the 'in' input of a downstream sequence detector.
module serial_tx_shifter #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             in_bit,
  output logic             bit_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hr_q, hr_d;
  logic             hr_full_q, hr_full_d;
  logic             accept;
  logic [WIDTH-1:0] sr_shift;

  // Ready depends only on HR occupancy, never on din_valid.
  assign din_ready = ~hr_full_q;
  assign accept    = din_valid & ~hr_full_q;
  assign sr_shift  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      hr_q      <= '0;
      hr_full_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      hr_q      <= hr_d;
      hr_full_q <= hr_full_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    hr_d      = hr_q;
    hr_full_d = hr_full_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_d    = din;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST) begin
          // Refill from HR first, else bypass a word arriving on this edge.
          cnt_d = '0;
          if (hr_full_q) begin
            sr_d      = hr_q;
            hr_full_d = 1'b0;
          end else if (accept) begin
            sr_d = din;
          end else begin
            sr_d    = sr_shift;
            state_d = S_IDLE;
          end
        end else begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + 1'b1;
          if (accept) begin
            hr_d      = din;
            hr_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign bit_valid = (state_q == S_SHIFT);
  assign in_bit    = bit_valid ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_BIT;
  assign busy      = bit_valid | hr_full_q;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: an MSB-first and an LSB-first instance share stimulus;
// a bit-queue reference model predicts the serial stream, ready and busy.
module tb_serial_tx_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         rdy1, b1, v1, busy1;
  logic         rdy2, b2, v2, busy2;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .in_bit(b1), .bit_valid(v1), .busy(busy1));

  serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy2), .in_bit(b2), .bit_valid(v2), .busy(busy2));

  // Reference: a queue of bits still to be emitted. More than W pending bits
  // means a second word is waiting, which is the only time input is refused.
  bit q1[$];
  bit q2[$];
  bit acc_last;

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    if (!rst_n) begin
      q1.delete();
      q2.delete();
      acc_last = 1'b0;
    end else begin
      acc = din_valid && (q1.size() <= W);
      if (q1.size() != 0) begin
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) q1.push_back(din[i]);
        for (int i = 0; i < W; i++)      q2.push_back(din[i]);
      end
      acc_last = acc;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vecs++;
    if ({rdy1, v1, b1, busy1} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_msb: got rdy/v/bit/busy=%b want 1000", {rdy1, v1, b1, busy1});
    end
    vecs++;
    if ({rdy2, v2, b2, busy2} !== 4'b1010) begin
      fails++;
      $display("FAIL reset_lsb: got rdy/v/bit/busy=%b want 1010", {rdy2, v2, b2, busy2});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Send one word from idle and check dut1 MSB-first and dut2 LSB-first bit order.
  task automatic send_single(input logic [W-1:0] w, input string nm);
    din = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      vecs++;
      if ({v1, b1} !== {1'b1, w[W-1-i]} || {v2, b2} !== {1'b1, w[i]}) begin
        fails++;
        $display("FAIL %s_bit%0d: got msb v/b=%b%b lsb v/b=%b%b want 1%b 1%b",
                 nm, i, v1, b1, v2, b2, w[W-1-i], w[i]);
      end
      @(posedge clk); #1;
    end
    vecs++;
    if ({v1, b1, busy1, rdy1} !== 4'b0001 || {v2, b2, busy2} !== 3'b010) begin
      fails++;
      $display("FAIL %s_after: got msb v/b/busy/rdy=%b%b%b%b lsb v/b/busy=%b%b%b want 0001 010",
               nm, v1, b1, busy1, rdy1, v2, b2, busy2);
    end
  endtask

  task automatic test_single();
    send_single(8'hA5, "single_A5");
  endtask

  task automatic test_lsb_first();
    send_single(8'h01, "lsb_01");
  endtask

  task automatic test_stream();
    logic [W-1:0] words [3];
    logic [3*W-1:0] exp;
    int  sent = 0;
    bit  saw_stall = 1'b0;
    words[0] = 8'hF0; words[1] = 8'h0F; words[2] = 8'h33;
    exp = {words[0], words[1], words[2]};
    din = words[0];
    din_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i <= 3 * W; i++) begin
      if (acc_last) begin
        sent++;
        if (sent < 3) din = words[sent];
        else din_valid = 1'b0;
      end
      if (!rdy1) saw_stall = 1'b1;
      vecs++;
      if (i < 3 * W) begin
        if ({v1, b1} !== {1'b1, exp[3*W-1-i]}) begin
          fails++;
          $display("FAIL stream_bit%0d: got v/b=%b%b want 1%b", i, v1, b1, exp[3*W-1-i]);
        end
      end else if ({v1, busy1} !== 2'b00) begin
        fails++;
        $display("FAIL stream_end: got v/busy=%b%b want 00", v1, busy1);
      end
      @(posedge clk); #1;
    end
    vecs++;
    if (saw_stall !== 1'b1 || sent !== 3) begin
      fails++;
      $display("FAIL stream_stall: got stall=%0d sent=%0d want 1 3", saw_stall, sent);
    end
  endtask

  task automatic test_bypass();
    logic [2*W-1:0] exp = 16'h5AC3;
    din = 8'h5A;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      if (i == W - 1) begin
        din = 8'hC3;
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      vecs++;
      if ({v1, b1, rdy1, busy1} !== {1'b1, exp[2*W-1-i], 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL bypass_bit%0d: got v/b/rdy/busy=%b%b%b%b want 1%b11",
                 i, v1, b1, rdy1, busy1, exp[2*W-1-i]);
      end
      @(posedge clk); #1;
    end
    vecs++;
    if ({v1, busy1} !== 2'b00) begin
      fails++;
      $display("FAIL bypass_end: got v/busy=%b%b want 00", v1, busy1);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w = 8'h80;
    din = 8'hFF;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'h3C;
    @(posedge clk); #1;
    din_valid = 1'b0;
    vecs++;
    if (rdy1 !== 1'b0) begin
      fails++;
      $display("FAIL midrst_hrfull: got rdy=%b want 0", rdy1);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({v1, rdy1, busy1, b1} !== 4'b0100 || {v2, rdy2, busy2, b2} !== 4'b0101) begin
      fails++;
      $display("FAIL midrst_async: got msb=%b%b%b%b lsb=%b%b%b%b want 0100 0101",
               v1, rdy1, busy1, b1, v2, rdy2, busy2, b2);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vecs++;
      if ({v1, busy1, b1} !== 3'b000) begin
        fails++;
        $display("FAIL midrst_stale%0d: got v/busy/b=%b%b%b want 000", i, v1, busy1, b1);
      end
    end
    din = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      vecs++;
      if ({v1, b1} !== {1'b1, w[W-1-i]}) begin
        fails++;
        $display("FAIL midrst_80_bit%0d: got v/b=%b%b want 1%b", i, v1, b1, w[W-1-i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Behavioural 1101 detector on the MSB-first stream, including idle fill.
  task automatic test_chain();
    logic [3:0] hist = 4'b0000;
    int det = 0;
    din = 8'hD0;
    din_valid = 1'b1;
    @(posedge clk); #1;
    hist = {hist[2:0], b1};
    if (hist == 4'b1101) det++;
    din = 8'hDD;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (acc_last) din_valid = 1'b0;
      hist = {hist[2:0], b1};
      if (hist == 4'b1101) det++;
    end
    vecs++;
    if (det !== 3) begin
      fails++;
      $display("FAIL chain_detect: got %0d pulses want 3", det);
    end
  endtask

  task automatic test_random();
    bit ev, eb1, eb2, er;
    for (int i = 0; i < 400; i++) begin
      if (!(din_valid && !acc_last)) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din = W'($urandom);
      end
      @(posedge clk); #1;
      ev  = (q1.size() != 0);
      eb1 = ev ? q1[0] : 1'b0;
      eb2 = ev ? q2[0] : 1'b1;
      er  = (q1.size() <= W);
      vecs++;
      if ({v1, b1, rdy1, busy1} !== {ev, eb1, er, ev} ||
          {v2, b2, rdy2, busy2} !== {ev, eb2, er, ev}) begin
        fails++;
        $display("FAIL random_cyc%0d: got msb=%b%b%b%b lsb=%b%b%b%b want %b%b%b%b %b%b%b%b",
                 i, v1, b1, rdy1, busy1, v2, b2, rdy2, busy2, ev, eb1, er, ev, ev, eb2, er, ev);
      end
    end
    din_valid = 1'b0;
    repeat (3 * W) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_stream();
    test_bypass();
    test_reset_mid();
    repeat (W + 2) @(posedge clk);
    #1;
    test_chain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/serial_tx_shifter.md
SERIAL_TX_SHIFTER -- requirements
Module: serial_tx_shifter

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out MSB first; 0 = shift out LSB first.
REQ-003 Parameter IDLE_BIT, default 1'b0: level driven on `in_bit` while no word is being shifted.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 din  input  WIDTH  parallel word to serialize.
REQ-007 din_valid  input  1  `din` holds a word offered for transfer.
REQ-008 din_ready  output  1  block can accept a word this cycle.
REQ-009 in_bit  output  1  serial bit stream; feeds the `in` input of the downstream sequence detector.
REQ-010 bit_valid  output  1  `in_bit` carries a payload bit this cycle.
REQ-011 busy  output  1  shifter active or holding register occupied.

Function
REQ-012 Transfer: a word SHALL be accepted at a rising edge where din_valid=1 and din_ready=1; no other handshake exists.
REQ-013 Storage: the block SHALL hold one shift register (SR) plus one holding register (HR), for at most 2 words in flight.
REQ-014 Control states SHALL be IDLE (SR empty) and SHIFT (SR active); a bit counter runs 0..WIDTH-1 in SHIFT.
REQ-015 din_ready SHALL equal NOT HR_full; it is driven from registers only, with no combinational path from din_valid.
REQ-016 IDLE + accept: the word SHALL load SR directly, move the state to SHIFT and set the counter to 0.
REQ-017 SHIFT: each edge SHALL advance SR by one bit toward the output end and increment the counter.
REQ-018 End of word: at the edge with counter=WIDTH-1, the next word SHALL come from the first available source below; the counter resets to 0 and the state stays SHIFT:
- HR, if HR_full; HR_full then clears.
- din, if HR is empty and a word is accepted on that same edge (bypass).
REQ-019 End of word with no next word: if neither source in REQ-018 applies, the state SHALL return to IDLE.
REQ-020 SHIFT + accept, other cases: a word accepted while in SHIFT that is not consumed by REQ-018 SHALL go to HR and set HR_full.
REQ-021 Latency: a word accepted at edge k SHALL drive its first bit on in_bit during the cycle after edge k, if SR was idle. Back-to-back words SHALL stream with zero gap cycles.
REQ-022 in_bit SHALL be SR[WIDTH-1] if MSB_FIRST=1, else SR[0], when bit_valid=1; it SHALL be IDLE_BIT when bit_valid=0.
REQ-023 bit_valid SHALL be 1 exactly while in SHIFT: WIDTH cycles per word.
REQ-024 busy SHALL be (state==SHIFT) OR HR_full.
REQ-025 in_bit and bit_valid SHALL come from flops only, with no combinational path from inputs.
REQ-026 din_valid while din_ready=0 SHALL be ignored; the upstream holds din stable until accepted.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge: set state IDLE, counter 0, SR 0, HR 0, HR_full 0.
REQ-028 During reset the outputs SHALL be din_ready=1, bit_valid=0, in_bit=IDLE_BIT, busy=0.
REQ-029 Reset asserted mid-word SHALL discard SR and HR contents; no partial bits follow the deassertion.
REQ-030 The first edge after rst_n deasserts SHALL behave as a normal IDLE-state edge and may accept a word.

Verification
REQ-031 Single word, WIDTH=8, MSB_FIRST=1: accept 8'hA5 at edge 1 -> in_bit = 1,0,1,0,0,1,0,1 over cycles 2-9, with bit_valid=1 in those cycles only. After that: in_bit=0, busy=0.
REQ-032 Streaming with din_valid held high: words 8'hF0, 8'h0F, 8'h33 -> 24 contiguous valid bits with no gap. din_ready drops to 0 while HR is full.
REQ-033 Bypass: HR empty, second word offered exactly at the counter=7 edge -> it loads SR directly, HR_full stays 0, and its first bit follows the prior word's last bit in the next cycle.
REQ-034 LSB first, MSB_FIRST=0: word 8'h01 -> in_bit = 1,0,0,0,0,0,0,0.
REQ-035 Reset mid-shift: rst_n=0 asserted after 3 bits of 8'hFF with HR full -> bit_valid=0 and din_ready=1 immediately. After deassertion no stale bits appear, and a new word 8'h80 serializes cleanly.
REQ-036 Chain test with the downstream detector on `in`: serialize a word containing that detector's target pattern -> exactly one detection pulse per pattern occurrence. Inter-word IDLE_BIT fill SHALL produce no spurious pulse in the test vectors.
